protobuf_varint_encoder: RTL and testbench
==========================================

// Module: protobuf_varint_encoder
// PURPOSE
//  Streaming protobuf base-128 varint encoder, one byte per clock.
//  Takes a value, plus an optional field key, over a valid/ready input.
//  Emits the encoded bytes LSB-group first over a valid/ready byte stream.
//  Sits between the AXI write decode (address 0x01, varint data) and the serializer byte FIFO.
// PARAMETERS
//  DATA_WIDTH   64  width of in_value (max 10 output bytes at 64)
//  FIELD_WIDTH  29  width of in_field; key = {field, wire_type}, max 5 bytes
// PORTS
//  clock_clk      in   1            single clock, all logic rising-edge
//  reset_reset_n  in   1            asynchronous assert, active-low reset
//  in_valid       in   1            item present
//  in_ready       out  1            item accepted when in_valid & in_ready
//  in_value       in   DATA_WIDTH   value to encode
//  in_zigzag      in   1            1: value is signed, zigzag-encode before varint
//  in_key_en      in   1            1: emit key varint before value
//  in_field       in   FIELD_WIDTH  field number, used when in_key_en=1
//  in_wire_type   in   3            wire type, used when in_key_en=1
//  out_valid      out  1            out_data valid
//  out_ready      in   1            byte consumed when out_valid & out_ready
//  out_data       out  8            encoded byte {continue_bit, 7 payload bits}
//  out_last       out  1            final byte of the item (value's last byte)
//  busy           out  1            item in flight (state != IDLE)
// BEHAVIOUR
//  Reset (async, low): state=IDLE; out_valid=0, out_data=0, out_last=0, busy=0.
//   in_ready=1 once reset deasserts. In-flight item is discarded; no partial bytes follow.
//  Input accept: latched on the edge where in_valid & in_ready.
//   key_sr = {field, wire_type}, zero-extended to 32 bits.
//   val_sr = zigzag ? (v<<1) ^ {DATA_WIDTH{v[MSB]}} : v.
//   Next state = KEY if in_key_en, else VALUE. Input fields are ignored while not ready.
//  Latency: out_valid=1 in the cycle after acceptance (1 cycle).
//  States: IDLE -> KEY -> VALUE -> IDLE, or IDLE -> VALUE -> IDLE.
//  Byte generation, shift register sr = key_sr in KEY, val_sr in VALUE:
//   more = |sr[W-1:7]; out_data = {more, sr[6:0]}; all from registered state.
//   Handshake with more=1: sr <= sr >> 7 (logical), stay in the current state.
//   Handshake with more=0 in KEY: go to VALUE.
//   Handshake with more=0 in VALUE: item done.
//   out_last = (state==VALUE) & ~more.
//  Value 0 emits exactly one 0x00 byte. Key with field 0 is emitted as given; no legality check.
//  Backpressure: while out_valid & ~out_ready, out_data, out_last and internal state hold stable.
//  in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
//   This allows back-to-back items with no bubble: a new item accepted on the last-byte
//   handshake edge goes straight to KEY/VALUE, and out_valid stays 1.
//  out_valid never drops without a handshake, except on reset.
//  No byte ever has continue_bit=1 together with out_last=1.
//  Byte count per item: key 1..5 plus value 1..ceil(DATA_WIDTH/7).
// TESTING
//  1. value=10, key_en=0, zigzag=0 -> single byte 0x0a with out_last=1.
//     Then value=51 back-to-back -> 0x33 on the next cycle, no gap.
//  2. key_en=1, field=1, wire=0, value=150 -> 08 96 01; out_last only on 01.
//  3. zigzag: value=-1 (all ones) -> 01; -2 -> 03; +1 -> 02. Each a single byte, last=1.
//  4. value=64'hFFFF_FFFF_FFFF_FFFF, zigzag=0 -> nine FF bytes, then 01 with last=1.
//     in_ready is low until that final handshake.
//  5. value=300, out_ready low 3 cycles after first byte -> AC held stable, then AC 02.
//     No byte lost or duplicated.
//  6. reset_reset_n low mid-item (after 1 of 3 bytes) -> out_valid=0 immediately.
//     After release, in_ready=1 and the next item (value=1) emits a clean 01.

Source files
------------

// File: rtl/protobuf_varint_encoder_if.sv
// Handshake bundle for the varint encoder: item input stream, byte output stream, busy flag.
interface protobuf_varint_encoder_if #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FIELD_WIDTH = 29
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_value;
  logic                   in_zigzag;
  logic                   in_key_en;
  logic [FIELD_WIDTH-1:0] in_field;
  logic [2:0]             in_wire_type;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic                   out_last;
  logic                   busy;

  // Producer of items and consumer of bytes.
  modport master (
    output in_valid, in_value, in_zigzag, in_key_en, in_field, in_wire_type, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_value, in_zigzag, in_key_en, in_field, in_wire_type, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/protobuf_varint_encoder.sv
// Streaming protobuf base-128 varint encoder. Emits an optional key varint followed by the
// value varint, one byte per clock, least-significant 7-bit group first.
module protobuf_varint_encoder #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FIELD_WIDTH = 29
) (
  input logic                   clock_clk,
  input logic                   reset_reset_n,
  protobuf_varint_encoder_if.slave io
);
  localparam int unsigned KeyWidth = 32;

  typedef enum logic [1:0] {StIdle, StKey, StValue} state_e;

  state_e                state_q;
  logic [KeyWidth-1:0]   key_q;
  logic [DATA_WIDTH-1:0] val_q;

  logic                  key_more;
  logic                  val_more;
  logic                  more;
  logic [6:0]            payload;
  logic                  out_valid;
  logic                  out_last;
  logic                  hs;
  logic                  in_ready;
  logic                  accept;
  logic [KeyWidth-1:0]   key_load;
  logic [DATA_WIDTH-1:0] val_load;

  assign key_more = |key_q[KeyWidth-1:7];
  assign val_more = |val_q[DATA_WIDTH-1:7];

  // Output byte and handshake terms, all derived from registered state.
  always_comb begin
    more    = 1'b0;
    payload = 7'd0;
    unique case (state_q)
      StKey: begin
        more    = key_more;
        payload = key_q[6:0];
      end
      StValue: begin
        more    = val_more;
        payload = val_q[6:0];
      end
      default: begin
        more    = 1'b0;
        payload = 7'd0;
      end
    endcase
    out_valid = (state_q != StIdle);
    out_last  = (state_q == StValue) & ~more;
    hs        = out_valid & io.out_ready;
    // Accepting on the final-byte handshake keeps the byte stream gap-free.
    in_ready  = (state_q == StIdle) | (hs & out_last);
    accept    = io.in_valid & in_ready;
  end

  // Key and (optionally zigzagged) value images loaded on acceptance.
  always_comb begin
    key_load = KeyWidth'({io.in_field, io.in_wire_type});
    if (io.in_zigzag) begin
      val_load = {io.in_value[DATA_WIDTH-2:0], 1'b0} ^ {DATA_WIDTH{io.in_value[DATA_WIDTH-1]}};
    end else begin
      val_load = io.in_value;
    end
  end

  // FSM: load on accept, shift 7 bits per handshake, advance when no groups remain.
  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      key_q   <= '0;
      val_q   <= '0;
    end else if (accept) begin
      key_q   <= key_load;
      val_q   <= val_load;
      state_q <= io.in_key_en ? StKey : StValue;
    end else if (hs) begin
      unique case (state_q)
        StKey: begin
          if (key_more) key_q <= key_q >> 7;
          else          state_q <= StValue;
        end
        StValue: begin
          if (val_more) val_q <= val_q >> 7;
          else          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.out_data  = {more, payload};
  assign io.out_last  = out_last;
  assign io.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_protobuf_varint_encoder.sv
// Directed bench for the varint encoder: drive and sample on the falling clock edge.
module tb_protobuf_varint_encoder;
  logic clk;
  logic rst_n;

  protobuf_varint_encoder_if #(.DATA_WIDTH(64), .FIELD_WIDTH(29)) bus ();

  protobuf_varint_encoder #(.DATA_WIDTH(64), .FIELD_WIDTH(29)) dut (
    .clock_clk     (clk),
    .reset_reset_n (rst_n),
    .io            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [7:0] cap_data [16];
  logic       cap_last [16];
  int         cap_n;
  bit         cap_to;
  int         cap_rdy_err;
  int         cap_cl_err;

  // Stimulus/capture only: offers one item, then records every byte until out_last.
  task automatic run_item(input logic [63:0] v, input logic zz, input logic ke,
                          input logic [28:0] f, input logic [2:0] w);
    int  guard;
    bit  done;
    cap_n = 0; cap_to = 0; cap_rdy_err = 0; cap_cl_err = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_value = v; bus.in_zigzag = zz;
    bus.in_key_en = ke; bus.in_field = f; bus.in_wire_type = w;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 50) cap_to = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    done  = 0;
    while (!done && guard < 50 && cap_n < 16) begin
      if (bus.out_valid) begin
        cap_data[cap_n] = bus.out_data;
        cap_last[cap_n] = bus.out_last;
        if (!bus.out_last && bus.in_ready) cap_rdy_err++;
        if (bus.out_last && bus.out_data[7]) cap_cl_err++;
        cap_n++;
        done = bus.out_last;
      end
      @(negedge clk);
      guard++;
    end
    if (!done) cap_to = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++;
      $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++;
      $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_value = 64'd10; bus.in_zigzag = 1'b0; bus.in_key_en = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++;
      $display("FAIL b2b_first_ready: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    bus.in_value = 64'd51;
    #1;
    n_cmp++; if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 8'h0a, 1'b1}) begin
      n_bad++; $display("FAIL b2b_byte0: got v=%b d=%h l=%b expected v=1 d=0a l=1",
                        bus.out_valid, bus.out_data, bus.out_last); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++;
      $display("FAIL b2b_ready_on_last: got %b expected 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 8'h33, 1'b1}) begin
      n_bad++; $display("FAIL b2b_byte1: got v=%b d=%h l=%b expected v=1 d=33 l=1",
                        bus.out_valid, bus.out_data, bus.out_last); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL b2b_idle_after: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_key();
    logic [7:0] exp_d [3];
    logic       exp_l [3];
    exp_d[0] = 8'h08; exp_d[1] = 8'h96; exp_d[2] = 8'h01;
    exp_l[0] = 1'b0;  exp_l[1] = 1'b0;  exp_l[2] = 1'b1;
    run_item(64'd150, 1'b0, 1'b1, 29'd1, 3'd0);
    n_cmp++; if (cap_to || cap_n != 3) begin n_bad++;
      $display("FAIL key_count: got %0d (timeout=%0d) expected 3", cap_n, cap_to); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (cap_data[i] !== exp_d[i] || cap_last[i] !== exp_l[i]) begin n_bad++;
        $display("FAIL key_byte%0d: got d=%h l=%b expected d=%h l=%b",
                 i, cap_data[i], cap_last[i], exp_d[i], exp_l[i]); end
    end
  endtask

  task automatic test_zigzag();
    logic [63:0] vals [3];
    logic [7:0]  exps [3];
    vals[0] = 64'hFFFF_FFFF_FFFF_FFFF; exps[0] = 8'h01;
    vals[1] = 64'hFFFF_FFFF_FFFF_FFFE; exps[1] = 8'h03;
    vals[2] = 64'd1;                   exps[2] = 8'h02;
    for (int i = 0; i < 3; i++) begin
      run_item(vals[i], 1'b1, 1'b0, 29'd0, 3'd0);
      n_cmp++;
      if (cap_to || cap_n != 1 || cap_data[0] !== exps[i] || cap_last[0] !== 1'b1) begin
        n_bad++; $display("FAIL zigzag%0d: got n=%0d d=%h l=%b expected n=1 d=%h l=1",
                          i, cap_n, cap_data[0], cap_last[0], exps[i]); end
    end
  endtask

  task automatic test_max_value();
    run_item(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 29'd0, 3'd0);
    n_cmp++; if (cap_to || cap_n != 10) begin n_bad++;
      $display("FAIL max_count: got %0d (timeout=%0d) expected 10", cap_n, cap_to); end
    for (int i = 0; i < 9; i++) begin
      n_cmp++; if (cap_data[i] !== 8'hFF || cap_last[i] !== 1'b0) begin n_bad++;
        $display("FAIL max_byte%0d: got d=%h l=%b expected d=ff l=0",
                 i, cap_data[i], cap_last[i]); end
    end
    n_cmp++; if (cap_data[9] !== 8'h01 || cap_last[9] !== 1'b1) begin n_bad++;
      $display("FAIL max_final: got d=%h l=%b expected d=01 l=1", cap_data[9], cap_last[9]); end
    n_cmp++; if (cap_rdy_err != 0) begin n_bad++;
      $display("FAIL max_in_ready_low: got %0d early-ready bytes expected 0", cap_rdy_err); end
    n_cmp++; if (cap_cl_err != 0) begin n_bad++;
      $display("FAIL max_cont_with_last: got %0d expected 0", cap_cl_err); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_value = 64'd300; bus.in_zigzag = 1'b0; bus.in_key_en = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus.out_valid, bus.out_data, bus.out_last, bus.in_ready} !== {1'b1, 8'hAC, 1'b0, 1'b0})
      begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%b d=%h l=%b r=%b expected v=1 d=ac l=0 r=0",
                          i, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready); end
      if (i < 3) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 8'h02, 1'b1}) begin
      n_bad++; $display("FAIL bp_second: got v=%b d=%h l=%b expected v=1 d=02 l=1",
                        bus.out_valid, bus.out_data, bus.out_last); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL bp_no_extra: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_item();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_value = 64'd20000; bus.in_zigzag = 1'b0; bus.in_key_en = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_data !== 8'hA0) begin n_bad++;
      $display("FAIL rst_mid_byte0: got %h expected a0", bus.out_data); end
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 8'h9C) begin n_bad++;
      $display("FAIL rst_mid_byte1: got %h expected 9c", bus.out_data); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++;
      $display("FAIL rst_mid_drop: got v=%b busy=%b expected 0 0", bus.out_valid, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_mid_release: got r=%b v=%b expected r=1 v=0",
               bus.in_ready, bus.out_valid); end
    run_item(64'd1, 1'b0, 1'b0, 29'd0, 3'd0);
    n_cmp++;
    if (cap_to || cap_n != 1 || cap_data[0] !== 8'h01 || cap_last[0] !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_next: got n=%0d d=%h l=%b expected n=1 d=01 l=1",
                        cap_n, cap_data[0], cap_last[0]); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.in_valid     = 1'b0;
    bus.in_value     = '0;
    bus.in_zigzag    = 1'b0;
    bus.in_key_en    = 1'b0;
    bus.in_field     = '0;
    bus.in_wire_type = '0;
    bus.out_ready    = 1'b1;
    test_reset();
    test_back_to_back();
    test_key();
    test_zigzag();
    test_max_value();
    test_backpressure();
    test_reset_mid_item();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
